// File: rtl/cache_pkg.sv
// Shared sizing parameters and FSM encoding for the cache fill controller.
package cache_pkg;

  localparam int WORD     = 32;
  localparam int ADDRESSL = 12;
  localparam int TAG      = 3;
  localparam int BLOCKL   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    FETCH  = 3'd2,
    FILL   = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/cache_line_buffer.sv
// Block fill buffer: memory words arrive one at a time and are stored at the
// position given by an internal write counter.
module cache_line_buffer #(
  parameter int WORD   = cache_pkg::WORD,
  parameter int BLOCKL = cache_pkg::BLOCKL
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        wr_i,
  input  logic [WORD-1:0]             wdata_i,
  output logic [BLOCKL-1:0][WORD-1:0] words_o,
  output logic [BLOCKL-1:0][WORD-1:0] words_next_o,
  output logic                        last_o
);

  localparam int CW = $clog2(BLOCKL);

  logic [CW-1:0]               cnt_q, cnt_d;
  logic [BLOCKL-1:0][WORD-1:0] buf_q, buf_d;

  // next buffer contents and write pointer
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wr_i) begin
      buf_d[cnt_q] = wdata_i;
      cnt_d        = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // buffer and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  // words_next_o lets the owner capture the block on the same edge that
  // stores its final word
  assign words_o      = buf_q;
  assign words_next_o = buf_d;
  assign last_o       = wr_i && !clr_i && (cnt_q == CW'(BLOCKL - 1));

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache read controller: looks up the cache and, on a miss, fetches a block
// serially from main memory, then writes it to the cache in a single cycle.
module cache_fill_ctrl #(
  parameter int WORD     = cache_pkg::WORD,
  parameter int ADDRESSL = cache_pkg::ADDRESSL,
  parameter int TAG      = cache_pkg::TAG,
  parameter int BLOCKL   = cache_pkg::BLOCKL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpuRead,
  input  logic [ADDRESSL+TAG-1:0] cpuAddress,
  output logic [WORD-1:0]         cpuData,
  output logic                    cpuReady,
  output logic [ADDRESSL+TAG-1:0] address,
  output logic                    cRead,
  input  logic                    hit,
  input  logic [WORD-1:0]         dataOutCache,
  output logic                    cWrite,
  output logic [ADDRESSL+TAG-1:0] adr0,
  output logic [ADDRESSL+TAG-1:0] adr1,
  output logic [ADDRESSL+TAG-1:0] adr2,
  output logic [ADDRESSL+TAG-1:0] adr3,
  output logic [WORD-1:0]         dataRtoC0,
  output logic [WORD-1:0]         dataRtoC1,
  output logic [WORD-1:0]         dataRtoC2,
  output logic [WORD-1:0]         dataRtoC3,
  output logic                    memRead,
  output logic [ADDRESSL+TAG-1:0] memAddress,
  input  logic [WORD-1:0]         memData,
  input  logic                    memReady,
  output logic [15:0]             hitCount,
  output logic [15:0]             missCount
);

  import cache_pkg::*;

  localparam int AW = ADDRESSL + TAG;
  localparam int OW = $clog2(BLOCKL);

  state_e                      state_q, state_d;
  logic [AW-1:0]               req_addr_q, req_addr_d;
  logic [WORD-1:0]             cpu_data_q, cpu_data_d;
  logic [15:0]                 hit_cnt_q, hit_cnt_d;
  logic [15:0]                 miss_cnt_q, miss_cnt_d;
  logic [BLOCKL-1:0][AW-1:0]   fill_adr_q, fill_adr_d;
  logic [BLOCKL-1:0][WORD-1:0] fill_data_q, fill_data_d;
  logic [BLOCKL-1:0][WORD-1:0] buf_words_s, buf_next_s;
  logic [AW-1:0]               base_s;
  logic                        buf_clr_s, buf_wr_s, buf_last_s;

  assign base_s    = {req_addr_q[AW-1:OW], {OW{1'b0}}};
  assign buf_clr_s = (state_q == LOOKUP) && !hit;
  assign buf_wr_s  = (state_q == FETCH) && memReady;

  cache_line_buffer #(.WORD(WORD), .BLOCKL(BLOCKL)) u_buf (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (buf_clr_s),
    .wr_i         (buf_wr_s),
    .wdata_i      (memData),
    .words_o      (buf_words_s),
    .words_next_o (buf_next_s),
    .last_o       (buf_last_s)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cpuRead ? LOOKUP : IDLE;
      LOOKUP:  state_d = hit ? DONE : FETCH;
      FETCH:   state_d = buf_last_s ? FILL : FETCH;
      FILL:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // strobes decoded from the registered state
  always_comb begin
    cRead    = 1'b0;
    cWrite   = 1'b0;
    memRead  = 1'b0;
    cpuReady = 1'b0;
    case (state_q)
      LOOKUP:  cRead    = 1'b1;
      FETCH:   memRead  = 1'b1;
      FILL:    cWrite   = 1'b1;
      DONE:    cpuReady = 1'b1;
      default: cRead    = 1'b0;
    endcase
  end

  // datapath next-state: request latch, read data, counters, fill image
  always_comb begin
    req_addr_d  = req_addr_q;
    cpu_data_d  = cpu_data_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    fill_adr_d  = fill_adr_q;
    fill_data_d = fill_data_q;
    case (state_q)
      IDLE: begin
        req_addr_d = cpuRead ? cpuAddress : req_addr_q;
      end
      LOOKUP: begin
        if (hit) begin
          cpu_data_d = dataOutCache;
          hit_cnt_d  = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
        end else begin
          miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
        end
      end
      FETCH: begin
        // the fill image is loaded as the last word lands, so it is stable for FILL
        if (buf_last_s) begin
          for (int k = 0; k < BLOCKL; k++) begin
            fill_adr_d[k] = base_s | AW'(k);
          end
          fill_data_d = buf_next_s;
        end else begin
          fill_data_d = fill_data_q;
        end
      end
      FILL: begin
        cpu_data_d = buf_words_s[req_addr_q[OW-1:0]];
      end
      default: begin
        cpu_data_d = cpu_data_q;
      end
    endcase
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr_q  <= '0;
      cpu_data_q  <= '0;
      hit_cnt_q   <= 16'd0;
      miss_cnt_q  <= 16'd0;
      fill_adr_q  <= '0;
      fill_data_q <= '0;
    end else begin
      req_addr_q  <= req_addr_d;
      cpu_data_q  <= cpu_data_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      fill_adr_q  <= fill_adr_d;
      fill_data_q <= fill_data_d;
    end
  end

  assign cpuData    = cpu_data_q;
  assign address    = req_addr_q;
  assign memAddress = base_s;
  assign hitCount   = hit_cnt_q;
  assign missCount  = miss_cnt_q;
  assign adr0       = fill_adr_q[0];
  assign adr1       = fill_adr_q[1];
  assign adr2       = fill_adr_q[2];
  assign adr3       = fill_adr_q[3];
  assign dataRtoC0  = fill_data_q[0];
  assign dataRtoC1  = fill_data_q[1];
  assign dataRtoC2  = fill_data_q[2];
  assign dataRtoC3  = fill_data_q[3];

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: a vector table for the basic hit/miss
// flow plus hand-written sequences for gaps, reset, disturbance, saturation.
module tb_cache_fill_ctrl;

  localparam logic [31:0] A0 = 32'hA000_00A0;
  localparam logic [31:0] A1 = 32'hA000_00A1;
  localparam logic [31:0] A2 = 32'hA000_00A2;
  localparam logic [31:0] A3 = 32'hA000_00A3;

  typedef struct {
    logic        rd;
    logic [14:0] addr;
    logic        hit;
    logic [31:0] cdata;
    logic        mrdy;
    logic [31:0] mdata;
    logic        e_ready;
    logic        e_cread;
    logic        e_mread;
    logic        e_cwrite;
    logic [14:0] e_addr;
    logic [14:0] e_maddr;
    logic [31:0] e_data;
    logic [15:0] e_hits;
    logic [15:0] e_miss;
    logic        e_fill;
  } vec_t;

  logic        clk, rst, cpuRead, hit, memReady;
  logic        cRead, cWrite, memRead, cpuReady;
  logic [14:0] cpuAddress, address, memAddress, adr0, adr1, adr2, adr3;
  logic [31:0] cpuData, dataOutCache, memData;
  logic [31:0] dataRtoC0, dataRtoC1, dataRtoC2, dataRtoC3;
  logic [15:0] hitCount, missCount;
  logic [3:0][14:0] adr_v;
  logic [3:0][31:0] dat_v;

  int n_vec = 0;
  int n_err = 0;

  assign adr_v = {adr3, adr2, adr1, adr0};
  assign dat_v = {dataRtoC3, dataRtoC2, dataRtoC1, dataRtoC0};

  cache_fill_ctrl dut (
    .clk(clk), .rst(rst), .cpuRead(cpuRead), .cpuAddress(cpuAddress),
    .cpuData(cpuData), .cpuReady(cpuReady), .address(address), .cRead(cRead),
    .hit(hit), .dataOutCache(dataOutCache), .cWrite(cWrite),
    .adr0(adr0), .adr1(adr1), .adr2(adr2), .adr3(adr3),
    .dataRtoC0(dataRtoC0), .dataRtoC1(dataRtoC1),
    .dataRtoC2(dataRtoC2), .dataRtoC3(dataRtoC3),
    .memRead(memRead), .memAddress(memAddress), .memData(memData),
    .memReady(memReady), .hitCount(hitCount), .missCount(missCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One complete miss from IDLE; gap idle cycles between words, optional
  // address change and cpuRead drop while the block is being fetched.
  task automatic miss_seq(input string nm, input logic [14:0] a, input logic [14:0] base,
                          input logic [3:0][31:0] w, input int gap, input bit disturb,
                          input logic [31:0] exp_data, input logic [15:0] exp_miss);
    cpuAddress = a; cpuRead = 1'b1; hit = 1'b0; memReady = 1'b0;
    step();
    chk({nm, ".lookup.cRead"}, cRead, 1'b1);
    if (!disturb) cpuRead = 1'b0;
    step();
    chk({nm, ".fetch.memRead"}, memRead, 1'b1);
    chk({nm, ".fetch.memAddress"}, memAddress, base);
    chk({nm, ".fetch.missCount"}, missCount, exp_miss);
    for (int k = 0; k < 4; k++) begin
      memReady = 1'b1; memData = w[k];
      step();
      if (disturb) begin
        cpuRead = 1'b0; cpuAddress = 15'h7FFF;
      end
      if (k < 3) begin
        chk($sformatf("%s.w%0d.memRead", nm, k), memRead, 1'b1);
        chk($sformatf("%s.w%0d.cWrite", nm, k), cWrite, 1'b0);
        for (int g = 0; g < gap; g++) begin
          memReady = 1'b0; memData = 32'hBAD0_0000 | 32'(g);
          step();
          chk($sformatf("%s.w%0d.g%0d.memRead", nm, k, g), memRead, 1'b1);
        end
      end
    end
    memReady = 1'b1; memData = 32'hFFFF_FFFF;
    chk({nm, ".fill.cWrite"}, cWrite, 1'b1);
    chk({nm, ".fill.memRead"}, memRead, 1'b0);
    chk({nm, ".fill.cpuReady"}, cpuReady, 1'b0);
    chk({nm, ".fill.address"}, address, a);
    chk({nm, ".fill.memAddress"}, memAddress, base);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s.fill.adr%0d", nm, k), adr_v[k], base + 15'(k));
      chk($sformatf("%s.fill.data%0d", nm, k), dat_v[k], w[k]);
    end
    step();
    memReady = 1'b0;
    chk({nm, ".done.cpuReady"}, cpuReady, 1'b1);
    chk({nm, ".done.cWrite"}, cWrite, 1'b0);
    chk({nm, ".done.cpuData"}, cpuData, exp_data);
    chk({nm, ".done.missCount"}, missCount, exp_miss);
    chk({nm, ".done.data0hold"}, dat_v[0], w[0]);
    step();
    chk({nm, ".idle.cpuReady"}, cpuReady, 1'b0);
    chk({nm, ".idle.adr3hold"}, adr_v[3], base + 15'd3);
    chk({nm, ".idle.data3hold"}, dat_v[3], w[3]);
  endtask

  initial begin
    vec_t vt [12];

    rst = 1'b1; cpuRead = 1'b0; cpuAddress = 15'h0; hit = 1'b0;
    dataOutCache = 32'h0; memReady = 1'b0; memData = 32'h0;

    // asynchronous reset, checked before any clock edge
    #3 rst = 1'b0;
    #1;
    chk("rst.cpuReady", cpuReady, 1'b0);
    chk("rst.cRead", cRead, 1'b0);
    chk("rst.cWrite", cWrite, 1'b0);
    chk("rst.memRead", memRead, 1'b0);
    chk("rst.cpuData", cpuData, 32'h0);
    chk("rst.hitCount", hitCount, 16'h0);
    chk("rst.missCount", missCount, 16'h0);
    chk("rst.address", address, 15'h0);
    step(); step();
    rst = 1'b1;

    //          rd    addr      hit   cdata         mrdy  mdata          rdy   crd   mrd   cwr   addr      maddr     data          hits    miss    fill
    vt[0]  = '{1'b1, 15'h0123, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 15'h0123, 15'h0120, 32'h0,        16'd0, 16'd0, 1'b0};
    vt[1]  = '{1'b0, 15'h0123, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 15'h0123, 15'h0120, 32'hDEADBEEF, 16'd1, 16'd0, 1'b0};
    vt[2]  = '{1'b0, 15'h0123, 1'b0, 32'h0,        1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0123, 15'h0120, 32'hDEADBEEF, 16'd1, 16'd0, 1'b0};
    vt[3]  = '{1'b0, 15'h0123, 1'b0, 32'h0,        1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0123, 15'h0120, 32'hDEADBEEF, 16'd1, 16'd0, 1'b0};
    vt[4]  = '{1'b1, 15'h0126, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 15'h0126, 15'h0124, 32'hDEADBEEF, 16'd1, 16'd0, 1'b0};
    vt[5]  = '{1'b0, 15'h0126, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 15'h0126, 15'h0124, 32'hDEADBEEF, 16'd1, 16'd1, 1'b0};
    vt[6]  = '{1'b0, 15'h0126, 1'b0, 32'h0,        1'b1, A0,           1'b0, 1'b0, 1'b1, 1'b0, 15'h0126, 15'h0124, 32'hDEADBEEF, 16'd1, 16'd1, 1'b0};
    vt[7]  = '{1'b0, 15'h0126, 1'b0, 32'h0,        1'b1, A1,           1'b0, 1'b0, 1'b1, 1'b0, 15'h0126, 15'h0124, 32'hDEADBEEF, 16'd1, 16'd1, 1'b0};
    vt[8]  = '{1'b0, 15'h0126, 1'b0, 32'h0,        1'b1, A2,           1'b0, 1'b0, 1'b1, 1'b0, 15'h0126, 15'h0124, 32'hDEADBEEF, 16'd1, 16'd1, 1'b0};
    vt[9]  = '{1'b0, 15'h0126, 1'b0, 32'h0,        1'b1, A3,           1'b0, 1'b0, 1'b0, 1'b1, 15'h0126, 15'h0124, 32'hDEADBEEF, 16'd1, 16'd1, 1'b1};
    vt[10] = '{1'b0, 15'h0126, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 15'h0126, 15'h0124, A2,           16'd1, 16'd1, 1'b1};
    vt[11] = '{1'b0, 15'h0126, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 15'h0126, 15'h0124, A2,           16'd1, 16'd1, 1'b1};

    for (int i = 0; i < 12; i++) begin
      cpuRead = vt[i].rd; cpuAddress = vt[i].addr; hit = vt[i].hit;
      dataOutCache = vt[i].cdata; memReady = vt[i].mrdy; memData = vt[i].mdata;
      step();
      chk($sformatf("v%0d.cpuReady", i), cpuReady, vt[i].e_ready);
      chk($sformatf("v%0d.cRead", i), cRead, vt[i].e_cread);
      chk($sformatf("v%0d.memRead", i), memRead, vt[i].e_mread);
      chk($sformatf("v%0d.cWrite", i), cWrite, vt[i].e_cwrite);
      chk($sformatf("v%0d.address", i), address, vt[i].e_addr);
      chk($sformatf("v%0d.memAddress", i), memAddress, vt[i].e_maddr);
      chk($sformatf("v%0d.cpuData", i), cpuData, vt[i].e_data);
      chk($sformatf("v%0d.hitCount", i), hitCount, vt[i].e_hits);
      chk($sformatf("v%0d.missCount", i), missCount, vt[i].e_miss);
      if (vt[i].e_fill) begin
        chk($sformatf("v%0d.adr", i), adr_v, {15'h0127, 15'h0126, 15'h0125, 15'h0124});
        chk($sformatf("v%0d.data", i), dat_v, {A3, A2, A1, A0});
      end
    end
    cpuRead = 1'b0; hit = 1'b0; memReady = 1'b0;

    // memReady with three idle cycles between words
    miss_seq("gap", 15'h0041, 15'h0040,
             {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000},
             3, 1'b0, 32'hB000_0001, 16'd2);

    // reset in the middle of a fetch
    cpuAddress = 15'h0200; cpuRead = 1'b1; hit = 1'b0;
    step();
    cpuRead = 1'b0;
    step();
    chk("rstf.memRead", memRead, 1'b1);
    chk("rstf.missCount", missCount, 16'd3);
    memReady = 1'b1; memData = 32'hC0C0_0000;
    step();
    memData = 32'hC0C0_0001;
    step();
    memReady = 1'b0;
    chk("rstf.midfetch.memRead", memRead, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rstf.async.memRead", memRead, 1'b0);
    chk("rstf.async.missCount", missCount, 16'd0);
    chk("rstf.async.hitCount", hitCount, 16'd0);
    chk("rstf.async.cpuData", cpuData, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    miss_seq("refetch", 15'h0200, 15'h0200,
             {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000},
             0, 1'b0, 32'hE000_0000, 16'd1);

    // address change and cpuRead drop during the fetch
    miss_seq("disturb", 15'h0301, 15'h0300,
             {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000},
             0, 1'b1, 32'hD000_0001, 16'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("disturb.after%0d.cpuReady", i), cpuReady, 1'b0);
      chk($sformatf("disturb.after%0d.cRead", i), cRead, 1'b0);
    end

    // saturation of hitCount, with cpuRead held high across DONE
    force dut.hit_cnt_q = 16'hFFFE;
    step();
    release dut.hit_cnt_q;
    step();
    chk("sat.preload", hitCount, 16'hFFFE);
    cpuAddress = 15'h0010; dataOutCache = 32'h5A5A_5A5A; hit = 1'b1; cpuRead = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("held.c%0d.cRead", i), cRead, (i % 3 == 0));
      chk($sformatf("held.c%0d.cpuReady", i), cpuReady, (i % 3 == 1));
      if (i == 1) chk("sat.first", hitCount, 16'hFFFF);
    end
    cpuRead = 1'b0; hit = 1'b0;
    chk("sat.final", hitCount, 16'hFFFF);
    chk("sat.missCount", missCount, 16'd2);
    chk("sat.cpuData", cpuData, 32'h5A5A_5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
